// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA controller and cpu/mem bus arbiter
// Copies one 256-byte page to the OAM data port while holding the cpu off the bus.
module oam_dma #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_DATA = 16'h2004
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_cpu_addr,
   input  logic        i_cpu_wen,
   input  logic [7:0]  i_cpu_wdata,
   output logic        o_cpu_rdy,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_wen,
   output logic [7:0]  o_mem_wdata,
   input  logic [7:0]  i_mem_rdata,
   output logic        o_dma_active
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic       r_parity;
   logic       w_start;

   assign w_start = (r_state == S_IDLE) && i_cpu_wen && (i_cpu_addr == DMA_REG);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_page   <= 8'h00;
         r_idx    <= 8'h00;
         r_parity <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_parity <= ~r_parity;
         if (w_start) begin
            r_page <= i_cpu_wdata;
            r_idx  <= 8'h00;
         end else if (r_state == S_WRITE) begin
            // 8-bit wrap keeps the source inside the page and leaves idx=0 when done
            r_idx <= r_idx + 8'h01;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_HALT;
         S_HALT:  w_next = r_parity ? S_READ : S_ALIGN;
         S_ALIGN: w_next = S_READ;
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wen   = 1'b0;
      o_mem_wdata = i_cpu_wdata;
      case (r_state)
         S_IDLE: begin
            o_mem_wen = i_cpu_wen;
         end
         S_READ: begin
            o_mem_addr = {r_page, r_idx};
         end
         S_WRITE: begin
            // read data arrives one cycle after the READ address and is forwarded as-is
            o_mem_addr  = OAM_DATA;
            o_mem_wen   = 1'b1;
            o_mem_wdata = i_mem_rdata;
         end
         default: begin
            o_mem_wen = 1'b0;
         end
      endcase
   end

   assign o_cpu_rdy    = (r_state == S_IDLE);
   assign o_dma_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma
// Memory model with one-cycle read latency; expected bytes come from the model array.
module tb_oam_dma;

   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_DATA = 16'h2004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_wen = 1'b0;
   logic [7:0]  cpu_wdata = 8'h00;
   logic        cpu_rdy;
   logic [15:0] mem_addr;
   logic        mem_wen;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        dma_active;

   logic [7:0]  mem [0:65535];
   int          errors = 0;
   int          checks = 0;
   int          cyc;

   oam_dma #(.DMA_REG(DMA_REG), .OAM_DATA(OAM_DATA)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wen    (cpu_wen),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_rdy    (cpu_rdy),
      .o_mem_addr   (mem_addr),
      .o_mem_wen    (mem_wen),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata),
      .o_dma_active (dma_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // cycle index since reset release; its low bit is the bus parity of that cycle
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic test_reset();
      rst = 1'b1;
      cpu_addr = 16'h1234; cpu_wen = 1'b1; cpu_wdata = 8'h5A;
      #1;
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", cpu_rdy); end
      checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", dma_active); end
      checks++; if (mem_addr !== 16'h1234 || mem_wen !== 1'b1 || mem_wdata !== 8'h5A) begin
         errors++; $display("FAIL reset_mux got=%h/%b/%h exp=1234/1/5a", mem_addr, mem_wen, mem_wdata);
      end
      cpu_wen = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         cpu_addr = 16'($urandom_range(0, 16'h3FFF));
         cpu_wen = 1'($urandom);
         cpu_wdata = 8'($urandom);
         @(negedge clk);
         checks++; if (mem_addr !== cpu_addr || mem_wen !== cpu_wen || mem_wdata !== cpu_wdata) begin
            errors++; $display("FAIL idle_mux got=%h/%b/%h exp=%h/%b/%h", mem_addr, mem_wen, mem_wdata, cpu_addr, cpu_wen, cpu_wdata);
         end
         checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            errors++; $display("FAIL idle_status got=%b/%b exp=1/0", cpu_rdy, dma_active);
         end
      end
      @(posedge clk); #1 cpu_wen = 1'b0;
   endtask

   // One full or aborted transfer; pre_driven means the trigger is already on the bus this cycle.
   task automatic run_xfer(input logic [7:0] pg, input logic [15:0] hold, input int abort_at,
                           input bit pre_driven, input bit chain, input logic [7:0] next_pg);
      int exp_stall, stall, pre, nr, nw;
      logic [15:0] last_rd;
      bit done;
      stall = 0; pre = 0; nr = 0; nw = 0; done = 0; last_rd = 16'h0000;
      if (!pre_driven) begin
         @(posedge clk); #1;
         cpu_addr = DMA_REG; cpu_wen = 1'b1; cpu_wdata = pg;
         @(negedge clk);
      end
      #1;
      exp_stall = (((cyc + 1) % 2) == 1) ? 513 : 514;
      checks++; if (mem_addr !== DMA_REG || mem_wen !== 1'b1 || mem_wdata !== pg || cpu_rdy !== 1'b1) begin
         errors++; $display("FAIL trigger_pass got=%h/%b/%h rdy=%b exp=%h/1/%h rdy=1", mem_addr, mem_wen, mem_wdata, cpu_rdy, DMA_REG, pg);
      end
      @(posedge clk); #1;
      cpu_addr = hold; cpu_wen = 1'b1; cpu_wdata = 8'hA5;
      for (int c = 0; c < 1000 && !done; c++) begin
         @(negedge clk);
         if (cpu_rdy) begin
            done = 1;
         end else begin
            stall++;
            checks++; if (dma_active !== 1'b1) begin errors++; $display("FAIL stall_active got=%b exp=1", dma_active); end
            if (mem_wen) begin
               checks++; if (mem_addr !== OAM_DATA || mem_wdata !== mem[{pg, nw[7:0]}]) begin
                  errors++; $display("FAIL oam_write n=%0d got=%h/%h exp=%h/%h", nw, mem_addr, mem_wdata, OAM_DATA, mem[{pg, nw[7:0]}]);
               end
               nw++;
               if (abort_at > 0 && nw == abort_at) begin
                  rst = 1'b1;
                  #1;
                  checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
                     errors++; $display("FAIL abort_status got=%b/%b exp=1/0", cpu_rdy, dma_active);
                  end
                  checks++; if (mem_addr !== hold || mem_wen !== 1'b1) begin
                     errors++; $display("FAIL abort_mux got=%h/%b exp=%h/1", mem_addr, mem_wen, hold);
                  end
                  cpu_wen = 1'b0;
                  @(posedge clk); #1 rst = 1'b0;
                  return;
               end
            end else if (mem_addr === hold) begin
               pre++;
            end else begin
               checks++; if (mem_addr !== {pg, nr[7:0]} || nr > 255) begin
                  errors++; $display("FAIL read_addr n=%0d got=%h exp=%h", nr, mem_addr, {pg, nr[7:0]});
               end
               last_rd = mem_addr;
               nr++;
            end
         end
      end
      checks++; if (!done) begin errors++; $display("FAIL xfer_timeout stall=%0d exp=%0d", stall, exp_stall); end
      checks++; if (stall != exp_stall) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", stall, exp_stall); end
      checks++; if (pre != exp_stall - 512) begin errors++; $display("FAIL halt_align got=%0d exp=%0d", pre, exp_stall - 512); end
      checks++; if (nw != 256 || nr != 256) begin errors++; $display("FAIL byte_count got=%0d/%0d exp=256/256", nw, nr); end
      checks++; if (last_rd !== {pg, 8'hFF}) begin errors++; $display("FAIL last_read got=%h exp=%h", last_rd, {pg, 8'hFF}); end
      if (chain) begin
         cpu_addr = DMA_REG; cpu_wdata = next_pg;
      end else begin
         checks++; if (mem_addr !== hold || mem_wen !== 1'b1 || dma_active !== 1'b0) begin
            errors++; $display("FAIL resume got=%h/%b/%b exp=%h/1/0", mem_addr, mem_wen, dma_active, hold);
         end
         @(posedge clk); #1 cpu_wen = 1'b0;
      end
   endtask

   task automatic test_parity(input bit par1);
      @(posedge clk); #1;
      if ((cyc % 2 == 0) != par1) begin @(posedge clk); #1; end
      // the task then aligns on the next edge, which flips parity once more
      if (((cyc + 1) % 2 == 0) != par1) begin @(posedge clk); #1; end
      run_xfer(8'h02, 16'h0300, 0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);
      test_reset();
      test_idle();
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);
      test_parity(1'b1);
      test_parity(1'b0);
      run_xfer(8'h02, 16'h0300, 100, 1'b0, 1'b0, 8'h00);
      run_xfer(8'h03, 16'h0150, 0, 1'b0, 1'b0, 8'h00);
      run_xfer(8'hFF, 16'h0300, 0, 1'b0, 1'b1, 8'h01);
      run_xfer(8'h01, 16'h0300, 0, 1'b1, 1'b0, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA controller and memory-bus arbiter between the cpu core and the shared `mem` port. A cpu write to the DMA register halts the cpu through `cpu_rdy` and takes over the bus. The block then copies one 256-byte page, `{page,8'h00}`..`{page,8'hFF}`, into the PPU OAM data port as alternating read/write cycles. When the copy is done it returns the bus to the cpu.

## Interface
Parameters:
- DMA_REG, 16'h4014, address whose cpu write starts a transfer (the data byte is the source page)
- OAM_DATA, 16'h2004, destination address written once per byte

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  cpu bus address this cycle
- cpu_wen  in  1  cpu write enable
- cpu_wdata  in  8  cpu write data
- cpu_rdy  out  1  1 = cpu owns the bus and may advance; 0 = cpu must hold its state
- mem_addr  out  16  address to mem
- mem_wen  out  1  write enable to mem
- mem_wdata  out  8  write data to mem
- mem_rdata  in  8  mem read data; valid the cycle after a read address is presented
- dma_active  out  1  1 while a transfer is in progress (any non-IDLE state)

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- Registers:
  - state (IDLE, HALT, ALIGN, READ, WRITE)
  - page[7:0]
  - idx[7:0]
  - parity (toggles every cycle; 0 = "get" cycle)
- Reset values: state=IDLE, page=0, idx=0, parity=0, so cpu_rdy=1 and dma_active=0.
- Bus mux (combinational from state):
  - IDLE: mem_addr/mem_wen/mem_wdata = cpu_addr/cpu_wen/cpu_wdata.
  - HALT, ALIGN: mem_addr=cpu_addr, mem_wen=0 (dummy read; cpu writes are suppressed).
  - READ: mem_addr={page,idx}, mem_wen=0.
  - WRITE: mem_addr=OAM_DATA, mem_wen=1, mem_wdata=mem_rdata (the byte read in the preceding READ).
- cpu_rdy=1 only in IDLE. dma_active = (state != IDLE).
- Transitions:
  - IDLE -> HALT when cpu_wen=1 and cpu_addr==DMA_REG. On the same edge page<=cpu_wdata and idx<=0. The triggering write itself is passed through to mem.
  - HALT -> READ if parity=1 during HALT; otherwise HALT -> ALIGN.
  - ALIGN -> READ unconditionally. Every READ therefore lands on parity=0.
  - READ -> WRITE.
  - WRITE -> READ with idx<=idx+1 when idx!=8'hFF.
  - WRITE -> IDLE with idx<=0 (8-bit wrap) when idx==8'hFF.
- Source address is page-bounded: idx wraps and never carries into page.
- DMA_REG writes while not in IDLE are impossible (cpu_rdy=0) and are ignored regardless of cpu_wen.
- Page values are not filtered: page 8'h40 and above read whatever mem returns.

## Timing
- Trigger write in cycle T; HALT is in T+1.
- Cycles with cpu_rdy=0:
  - 513 = 1 HALT + 512 R/W when HALT parity=1.
  - 514 = HALT + ALIGN + 512 when HALT parity=0.
- cpu_rdy rises in the cycle after the final WRITE. The cpu resumes that cycle with its bus request honoured.
- Per byte: READ presents the address in cycle n; mem_rdata is valid in n+1 (WRITE) and is forwarded unregistered to mem_wdata.
- Back-to-back: a DMA_REG write in the first IDLE cycle after completion starts a new transfer normally.
- Reset asserted mid-transfer: outputs return to IDLE values immediately (asynchronous). The partial OAM contents are left as written; no resume.
- parity runs freely, including during reset release: it is 0 in the first cycle after rst deasserts.

## Test plan
- Reset, then 10 idle cycles of cpu accesses: mem_* equals cpu_* every cycle, cpu_rdy=1, dma_active=0.
- Preload 0x0200..0x02FF with data=low address byte; write 8'h02 to 4014 with HALT on parity=1: 513 stall cycles, 256 writes to 2004 with data 00..FF in order, mem_wen never 1 on any other address.
- Same transfer with the trigger shifted one cycle so HALT has parity=0: 514 stall cycles, exactly one ALIGN cycle, identical write sequence.
- During the stall, hold cpu_wen=1 with cpu_addr=0x0300: no write reaches mem; cpu_rdy=0 until the cycle after the final WRITE.
- Assert rst at the 100th WRITE: cpu_rdy=1 and dma_active=0 in the same cycle, idx=0. A new 4014 write of 8'h03 then copies 0x0300..0x03FF from idx 0.
- Page 8'hFF transfer: the last read address is FFFF, idx wraps to 0, and no access to 0x0000 occurs.
